// File: rtl/sm_display_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyph table,
// scan phase type and output polarity helper.
package sm_display_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SA = 7'b1 << SEG_A;
    localparam logic [6:0] SB = 7'b1 << SEG_B;
    localparam logic [6:0] SC = 7'b1 << SEG_C;
    localparam logic [6:0] SD = 7'b1 << SEG_D;
    localparam logic [6:0] SE = 7'b1 << SEG_E;
    localparam logic [6:0] SF = 7'b1 << SEG_F;
    localparam logic [6:0] SG = 7'b1 << SEG_G;

    // Active-high glyphs, {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_SEG [16] = '{
        SA | SB | SC | SD | SE | SF,       // 0
        SB | SC,                           // 1
        SA | SB | SD | SE | SG,            // 2
        SA | SB | SC | SD | SG,            // 3
        SB | SC | SF | SG,                 // 4
        SA | SC | SD | SF | SG,            // 5
        SA | SC | SD | SE | SF | SG,       // 6
        SA | SB | SC,                      // 7
        SA | SB | SC | SD | SE | SF | SG,  // 8
        SA | SB | SC | SD | SF | SG,       // 9
        SA | SB | SC | SE | SF | SG,       // A
        SC | SD | SE | SF | SG,            // b
        SA | SD | SE | SF,                 // C
        SB | SC | SD | SE | SG,            // d
        SA | SD | SE | SF | SG,            // E
        SA | SE | SF | SG                  // F
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    function automatic logic [6:0] segLevel(input logic [6:0] s, input bit activeLow);
        return activeLow ? ~s : s;
    endfunction

endpackage

// File: rtl/sm_hex2seg.sv
// Combinational nibble to active-high 7-segment code.
module sm_hex2seg
    import sm_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/sm_hex_display_scan.sv
// Multiplexed hex 7-segment scanner with per-frame snapshot, inter-digit
// blanking and optional leading-zero suppression.
module sm_hex_display_scan
    import sm_display_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned SCAN_SHIFT    = 10,
    parameter int unsigned BLANK_CYCLES  = 64,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dpMask,
    input  logic                  hold,
    output logic [DIGITS-1:0]     digitEn,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frameDone
);

    localparam int unsigned           IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [SCAN_SHIFT-1:0] BLANK_END = SCAN_SHIFT'(BLANK_CYCLES);

    if (DIGITS < 1 || DIGITS > 8 || SCAN_SHIFT < 2 || BLANK_CYCLES < 1 ||
        64'(BLANK_CYCLES) >= (64'd1 << SCAN_SHIFT)) begin : gBadParams
        $error("sm_hex_display_scan: parameter out of range");
    end

    logic [SCAN_SHIFT-1:0]   cnt;
    logic [IDX_W-1:0]        idx;
    logic [DIGITS-1:0][3:0]  snap;
    logic [DIGITS-1:0]       dpSnap;

    phase_t             phase;
    logic               tick;
    logic               lastSlot;
    logic [3:0]         curNib;
    logic [6:0]         hexSeg;
    logic [DIGITS-1:0]  nonZero;
    logic               curBlank;
    logic [DIGITS-1:0]  nextEn;
    logic [6:0]         nextSeg;
    logic               nextDp;

    sm_hex2seg uHex2seg (
        .nibble (curNib),
        .seg    (hexSeg)
    );

    always_comb begin
        tick     = &cnt;
        lastSlot = tick && (idx == LAST_IDX);
        phase    = (cnt < BLANK_END) ? PH_BLANK : PH_SHOW;
        curNib   = snap[idx];

        nonZero = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nonZero[k] = |snap[k];
        end
        // Digit is a leading zero when it and every higher nibble are zero
        curBlank = BLANK_LEADING && (idx != '0) && ((nonZero >> idx) == '0) && !dpSnap[idx];

        nextEn  = '0;
        nextSeg = '0;
        nextDp  = 1'b0;
        if (phase == PH_SHOW) begin
            nextEn[idx] = 1'b1;
            if (!curBlank) begin
                nextSeg = hexSeg;
                nextDp  = dpSnap[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            snap      <= '0;
            dpSnap    <= '0;
            digitEn   <= {DIGITS{ACTIVE_LOW}};
            seg       <= {7{ACTIVE_LOW}};
            dp        <= ACTIVE_LOW;
            frameDone <= 1'b0;
        end else begin
            cnt <= cnt + SCAN_SHIFT'(1);
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            if (lastSlot && !hold) begin
                snap   <= data;
                dpSnap <= dpMask;
            end
            digitEn   <= nextEn ^ {DIGITS{ACTIVE_LOW}};
            seg       <= segLevel(nextSeg, ACTIVE_LOW);
            dp        <= nextDp ^ ACTIVE_LOW;
            frameDone <= lastSlot;
        end
    end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Bench for sm_hex_display_scan: active-high and active-low instances share
// stimulus; cycle reference model feeds a scoreboard, plus per-frame glyph table.
module tb_sm_hex_display_scan;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dpMask;
    logic        hold;
    logic [7:0]  enH, enL;
    logic [6:0]  segH, segL;
    logic        dpH, dpL, fdH, fdL;

    int checks = 0;
    int errors = 0;

    sm_hex_display_scan #(
        .DIGITS(8), .SCAN_SHIFT(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dpMask(dpMask), .hold(hold),
        .digitEn(enH), .seg(segH), .dp(dpH), .frameDone(fdH)
    );

    sm_hex_display_scan #(
        .DIGITS(8), .SCAN_SHIFT(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dutL (
        .clk(clk), .rst(rst), .data(data), .dpMask(dpMask), .hold(hold),
        .digitEn(enL), .seg(segL), .dp(dpL), .frameDone(fdL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] BL = 7'h00;
    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F;
    localparam logic [6:0] S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07;
    localparam logic [6:0] S8 = 7'h7F, S9 = 7'h6F, SAx = 7'h77, Sb = 7'h7C;
    localparam logic [6:0] SCx = 7'h39, Sd = 7'h5E, SEx = 7'h79, SFx = 7'h71;
    localparam logic [6:0] GLYPH [16] = '{S0, S1, S2, S3, S4, S5, S6, S7,
                                          S8, S9, SAx, Sb, SCx, Sd, SEx, SFx};

    typedef logic [7:0][6:0] segs_t;
    typedef struct {
        logic [31:0] data;
        logic [7:0]  dpMask;
        logic        hold;
        segs_t       expSeg;
        logic [7:0]  expDp;
    } vec_t;

    typedef struct {
        logic [7:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb [$];

    int unsigned mCnt, mIdx;
    logic [31:0] mSnap;
    logic [7:0]  mDp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCnt  = 0;
        mIdx  = 0;
        mSnap = '0;
        mDp   = '0;
        sb.delete();
    endtask

    // One clock: predict registered outputs from model state, advance, compare.
    task automatic step();
        exp_t e, g;
        logic show, blank, allz;
        logic [3:0] nib;
        logic [7:0] invEn;
        logic [6:0] invSeg;
        show  = (mCnt >= 2);
        nib   = mSnap[mIdx*4 +: 4];
        blank = 1'b0;
        if (mIdx != 0) begin
            allz = 1'b1;
            for (int j = int'(mIdx); j < 8; j++) begin
                if (mSnap[j*4 +: 4] != 4'h0) allz = 1'b0;
            end
            blank = allz && !mDp[mIdx];
        end
        e.en  = show ? (8'h01 << mIdx) : 8'h00;
        e.seg = (show && !blank) ? GLYPH[nib] : 7'h00;
        e.dp  = show && !blank && mDp[mIdx];
        e.fd  = (mCnt == 15) && (mIdx == 7);
        sb.push_back(e);
        if (mCnt == 15 && mIdx == 7 && !hold) begin
            mSnap = data;
            mDp   = dpMask;
        end
        if (mCnt == 15) mIdx = (mIdx == 7) ? 0 : mIdx + 1;
        mCnt = (mCnt + 1) % 16;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        invEn  = ~g.en;
        invSeg = ~g.seg;
        chk("digitEn", 32'(enH), 32'(g.en));
        chk("seg", 32'(segH), 32'(g.seg));
        chk("dp", 32'(dpH), 32'(g.dp));
        chk("frameDone", 32'(fdH), 32'(g.fd));
        chk("digitEnL", 32'(enL), 32'(invEn));
        chk("segL", 32'(segL), 32'(invSeg));
        chk("dpL", 32'(dpL), 32'(!g.dp));
        chk("frameDoneL", 32'(fdL), 32'(g.fd));
        @(negedge clk);
    endtask

    task automatic syncTo(input int unsigned ti, input int unsigned tc);
        int n;
        n = 0;
        while (!(mIdx == ti && mCnt == tc) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL syncTo: got timeout want idx %0d cnt %0d", ti, tc);
        end
    endtask

    // Runs one full frame from slot 0, checking each digit mid-SHOW.
    task automatic runFrame(input segs_t expSeg, input logic [7:0] expDp,
                            input int midSlot, input logic [31:0] midData);
        logic [6:0] inv;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 16; c++) begin
                if (d == midSlot && c == 0) data = midData;
                step();
                if (c == 8) begin
                    inv = ~expSeg[d];
                    chk("rowSeg", 32'(segH), 32'(expSeg[d]));
                    chk("rowDp", 32'(dpH), 32'(expDp[d]));
                    chk("rowEn", 32'(enH), 32'(8'h01 << d));
                    chk("rowSegL", 32'(segL), 32'(inv));
                end
            end
        end
    endtask

    vec_t tbl [9];

    initial begin
        int n;
        tbl[0] = '{32'h1234_5678, 8'h00, 1'b0, {S1, S2, S3, S4, S5, S6, S7, S8}, 8'h00};
        tbl[1] = '{32'h1234_5678, 8'h01, 1'b0, {S1, S2, S3, S4, S5, S6, S7, S8}, 8'h01};
        tbl[2] = '{32'h0000_00A0, 8'h00, 1'b0, {BL, BL, BL, BL, BL, BL, SAx, S0}, 8'h00};
        tbl[3] = '{32'h0000_0000, 8'h08, 1'b0, {BL, BL, BL, BL, S0, BL, BL, S0}, 8'h08};
        tbl[4] = '{32'hFEDC_BA90, 8'h00, 1'b0, {SFx, SEx, Sd, SCx, Sb, SAx, S9, S0}, 8'h00};
        tbl[5] = '{32'h0001_0000, 8'h01, 1'b0, {BL, BL, BL, S1, S0, S0, S0, S0}, 8'h01};
        tbl[6] = '{32'h1111_1111, 8'h00, 1'b0, {8{S1}}, 8'h00};
        tbl[7] = '{32'h2222_2222, 8'h00, 1'b1, {8{S1}}, 8'h00};
        tbl[8] = '{32'h2222_2222, 8'h00, 1'b0, {8{S2}}, 8'h00};

        rst = 1'b1;
        data = '0;
        dpMask = '0;
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstEn", 32'(enH), 32'h00);
        chk("rstSeg", 32'(segH), 32'h00);
        chk("rstEnL", 32'(enL), 32'hFF);
        chk("rstSegL", 32'(segL), 32'h7F);
        chk("rstDpL", 32'(dpL), 32'h1);
        rst = 1'b0;
        modelReset();

        for (int r = 0; r < 9; r++) begin
            data   = tbl[r].data;
            dpMask = tbl[r].dpMask;
            hold   = tbl[r].hold;
            step();
            syncTo(0, 0);
            runFrame(tbl[r].expSeg, tbl[r].expDp, -1, '0);
        end

        // Mid-frame data change must not tear the frame in progress
        data = 32'h8765_4321;
        dpMask = 8'h00;
        hold = 1'b0;
        step();
        syncTo(0, 0);
        runFrame({S8, S7, S6, S5, S4, S3, S2, S1}, 8'h00, 4, 32'hCAFE_F00D);
        runFrame({SCx, SAx, SFx, SEx, SFx, S0, S0, Sd}, 8'h00, -1, '0);

        // Asynchronous reset mid-frame with digit 3 lit
        syncTo(3, 8);
        step();
        chk("preRstEn", 32'(enH), 32'h08);
        rst = 1'b1;
        #1;
        chk("asyncRstEn", 32'(enH), 32'h00);
        chk("asyncRstSeg", 32'(segH), 32'h00);
        chk("asyncRstDp", 32'(dpH), 32'h0);
        chk("asyncRstFd", 32'(fdH), 32'h0);
        chk("asyncRstEnL", 32'(enL), 32'hFF);
        chk("asyncRstSegL", 32'(segL), 32'h7F);
        chk("asyncRstDpL", 32'(dpL), 32'h1);
        modelReset();
        @(posedge clk);
        #1;
        chk("rstHoldEn", 32'(enH), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!fdH && n < 200);
        chk("firstFrameDone", 32'(n), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
